// File: rtl/axis_vote_scheduler.sv
// axis_vote_scheduler: takes one sample per round, broadcasts it to three
// classifier lanes, collects one result per lane and emits the bundle.
// Optional feature macro: AXIS_VOTE_SCHED_TIMEOUT_EN enables the COLLECT
// timeout, stale-lane tracking and the timeout_count counter.
//
// Handshake rule on every channel: a beat transfers on a rising clk edge
// where valid and ready are both high; a source holds valid and its payload
// stable until that edge, and valid never depends on ready.
module axis_vote_scheduler #(
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic                    s_axis_tlast,
  output logic [DATA_WIDTH-1:0]   m_req_tdata,
  output logic                    m_req_tlast,
  output logic [2:0]              m_req_tvalid,
  input  logic [2:0]              m_req_tready,
  input  logic [3*DATA_WIDTH-1:0] s_res_tdata,
  input  logic [2:0]              s_res_tvalid,
  output logic [2:0]              s_res_tready,
  output logic [3*DATA_WIDTH-1:0] m_vote_tdata,
  output logic                    m_vote_tvalid,
  input  logic                    m_vote_tready,
  output logic                    m_vote_tlast,
  output logic [2:0]              m_vote_lanes,
  output logic                    busy,
  output logic [15:0]             timeout_count,
  output logic [1:0]              state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DISPATCH = 2'd1,
    S_COLLECT  = 2'd2,
    S_EMIT     = 2'd3
  } state_t;

  state_t                  state, state_nxt;
  logic [DATA_WIDTH-1:0]   sample_q;
  logic                    last_q;
  logic [2:0]              pend, got, lanes_q, stale;
  logic [3*DATA_WIDTH-1:0] res_q;
  logic [2:0]              req_hs, res_hs, cap, got_nxt, pend_nxt;
  logic                    all_got, expire;

  assign req_hs   = m_req_tvalid & m_req_tready;
  assign res_hs   = s_res_tvalid & s_res_tready;
  assign pend_nxt = pend & ~req_hs;
  // Stale-lane beats are flushed, never captured.
  assign cap      = (state == S_COLLECT) ? (res_hs & ~stale) : 3'b000;
  assign got_nxt  = got | cap;
  assign all_got  = (got_nxt == 3'b111);

  assign m_req_tdata   = sample_q;
  assign m_req_tlast   = last_q;
  assign m_vote_tdata  = res_q;
  assign m_vote_tlast  = last_q;
  assign m_vote_lanes  = lanes_q;
  assign state_dbg     = state;

`ifdef AXIS_VOTE_SCHED_TIMEOUT_EN
  localparam logic [15:0] TMAX = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] timer, tcount;

  // A result landing in the expiry cycle is already in got_nxt, so it counts.
  assign expire        = (state == S_COLLECT) && (timer == TMAX) && !all_got;
  assign timeout_count = tcount;

  // Timer, stale mask and saturating timeout counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer  <= 16'h0000;
      stale  <= 3'b000;
      tcount <= 16'h0000;
    end else begin
      if (state == S_DISPATCH && pend_nxt == 3'b000) timer <= 16'h0000;
      else if (state == S_COLLECT)                   timer <= timer + 16'd1;
      stale <= (stale & ~res_hs) | (expire ? ~got_nxt : 3'b000);
      if (expire && tcount != 16'hFFFF) tcount <= tcount + 16'd1;
    end
  end
`else
  assign expire        = 1'b0;
  assign stale         = 3'b000;
  assign timeout_count = 16'h0000;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (s_axis_tvalid)         state_nxt = S_DISPATCH;
      S_DISPATCH: if (pend_nxt == 3'b000)    state_nxt = S_COLLECT;
      S_COLLECT:  if (all_got || expire)     state_nxt = S_EMIT;
      S_EMIT:     if (m_vote_tready)         state_nxt = S_IDLE;
      default:                               state_nxt = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from state and lane masks.
  always_comb begin
    s_axis_tready = 1'b0;
    m_req_tvalid  = 3'b000;
    s_res_tready  = stale;
    m_vote_tvalid = 1'b0;
    busy          = (state != S_IDLE);
    case (state)
      S_IDLE:     s_axis_tready = 1'b1;
      S_DISPATCH: m_req_tvalid  = pend;
      S_COLLECT:  s_res_tready  = ~got | stale;
      S_EMIT:     m_vote_tvalid = 1'b1;
      default:    ;
    endcase
  end

  // Sample latch, dispatch/collect masks and result capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_q <= '0;
      last_q   <= 1'b0;
      pend     <= 3'b000;
      got      <= 3'b000;
      lanes_q  <= 3'b000;
      res_q    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (s_axis_tvalid) begin
            sample_q <= s_axis_tdata;
            last_q   <= s_axis_tlast;
            pend     <= 3'b111;
          end
        end
        S_DISPATCH: begin
          pend <= pend_nxt;
          if (pend_nxt == 3'b000) begin
            got   <= 3'b000;
            res_q <= '0;
          end
        end
        S_COLLECT: begin
          got <= got_nxt;
          for (int i = 0; i < 3; i++) begin
            if (cap[i]) res_q[i*DATA_WIDTH +: DATA_WIDTH] <= s_res_tdata[i*DATA_WIDTH +: DATA_WIDTH];
          end
          if (all_got)     lanes_q <= 3'b111;
          else if (expire) lanes_q <= got_nxt;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_vote_scheduler.sv
// tb_axis_vote_scheduler: directed bench for axis_vote_scheduler.
// Expected vote beats are queued as {lanes, tlast, tdata} and matched
// against every m_vote handshake seen by the monitor.
`timescale 1ns/1ps
module tb_axis_vote_scheduler;

  localparam int DW = 32;
  localparam int W  = 100;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [DW-1:0]  s_axis_tdata = '0;
  logic           s_axis_tvalid = 1'b0;
  logic           s_axis_tready;
  logic           s_axis_tlast = 1'b0;
  logic [DW-1:0]  m_req_tdata;
  logic           m_req_tlast;
  logic [2:0]     m_req_tvalid;
  logic [2:0]     m_req_tready = 3'b000;
  logic [3*DW-1:0] s_res_tdata = '0;
  logic [2:0]     s_res_tvalid = 3'b000;
  logic [2:0]     s_res_tready;
  logic [3*DW-1:0] m_vote_tdata;
  logic           m_vote_tvalid;
  logic           m_vote_tready = 1'b0;
  logic           m_vote_tlast;
  logic [2:0]     m_vote_lanes;
  logic           busy;
  logic [15:0]    timeout_count;
  logic [1:0]     state_dbg;

  int n_cmp = 0;
  int n_err = 0;
  int vote_cnt = 0;
  logic [W-1:0] exp_q[$];

  axis_vote_scheduler #(.DATA_WIDTH(DW), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .m_req_tdata(m_req_tdata), .m_req_tlast(m_req_tlast),
    .m_req_tvalid(m_req_tvalid), .m_req_tready(m_req_tready),
    .s_res_tdata(s_res_tdata), .s_res_tvalid(s_res_tvalid), .s_res_tready(s_res_tready),
    .m_vote_tdata(m_vote_tdata), .m_vote_tvalid(m_vote_tvalid),
    .m_vote_tready(m_vote_tready), .m_vote_tlast(m_vote_tlast),
    .m_vote_lanes(m_vote_lanes), .busy(busy), .timeout_count(timeout_count),
    .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [W-1:0] pk(input logic [2:0] l, input logic t,
                                     input logic [31:0] d2, input logic [31:0] d1, input logic [31:0] d0);
    return {l, t, d2, d1, d0};
  endfunction

  // Scoreboard: every vote handshake must match the head of exp_q.
  always @(negedge clk) begin
    if (!rst && m_vote_tvalid && m_vote_tready) begin
      vote_cnt++;
      if (exp_q.size() == 0) check("vote_unexpected", 1, 0);
      else check("vote", {m_vote_lanes, m_vote_tlast, m_vote_tdata}, exp_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_sample(input logic [DW-1:0] d, input logic l);
    bit done = 0;
    s_axis_tdata  = d;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (s_axis_tready) done = 1;
      @(posedge clk); #1;
    end
    s_axis_tvalid = 1'b0;
    if (!done) check("send_timeout", 0, 1);
  endtask

  task automatic wait_vote_valid(input int budget, output int lat);
    lat = 0;
    while (lat < budget) begin
      @(negedge clk);
      lat++;
      if (m_vote_tvalid) break;
    end
    if (!m_vote_tvalid) check("vote_valid_timeout", 0, 1);
  endtask

  task automatic wait_state(input logic [1:0] st, input int budget);
    int n = 0;
    @(negedge clk);
    while (state_dbg != st && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (state_dbg != st) check("state_wait_timeout", state_dbg, st);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    int vc0;

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_s_axis_tready", s_axis_tready, 1);
    check("rst_busy", busy, 0);
    check("rst_req_tvalid", m_req_tvalid, 0);
    check("rst_vote_tvalid", m_vote_tvalid, 0);
    check("rst_vote_lanes", m_vote_lanes, 0);
    check("rst_res_tready", s_res_tready, 0);
    check("rst_timeout_count", timeout_count, 0);
    check("rst_vote_tdata", m_vote_tdata, 0);
    @(posedge clk); #1;

    // Round 1: everything ready, results 5/5/7, latency 3
    m_req_tready  = 3'b111;
    m_vote_tready = 1'b1;
    s_res_tvalid  = 3'b111;
    s_res_tdata   = {32'd7, 32'd5, 32'd5};
    exp_q.push_back(pk(3'b111, 1'b1, 32'd7, 32'd5, 32'd5));
    send_sample(32'h11, 1'b1);
    wait_vote_valid(20, lat);
    check("r1_latency", lat, 3);
    @(posedge clk); #1;

    // Round 2: lane 1 request ready held off for 4 cycles
    m_req_tready = 3'b101;
    s_res_tdata  = {32'd3, 32'd2, 32'd1};
    exp_q.push_back(pk(3'b111, 1'b0, 32'd3, 32'd2, 32'd1));
    send_sample(32'h22, 1'b0);
    @(negedge clk);
    check("r2_req_tvalid_first", m_req_tvalid, 3'b111);
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("r2_req_tvalid_hold", m_req_tvalid, 3'b010);
      check("r2_req_tdata_hold", m_req_tdata, 32'h22);
      check("r2_state_dispatch", state_dbg, 2'd1);
      if (i == 3) m_req_tready = 3'b111;
    end
    @(posedge clk); #1;
    @(negedge clk);
    check("r2_state_collect", state_dbg, 2'd2);
    check("r2_req_tvalid_off", m_req_tvalid, 3'b000);
    wait_vote_valid(20, lat);
    @(posedge clk); #1;

    // Round 3: vote back-pressure for several cycles
    m_vote_tready = 1'b0;
    s_res_tdata   = {32'hC, 32'hB, 32'hA};
    exp_q.push_back(pk(3'b111, 1'b1, 32'hC, 32'hB, 32'hA));
    send_sample(32'h33, 1'b1);
    wait_vote_valid(20, lat);
    check("r3_latency", lat, 3);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("r3_vote_tvalid_hold", m_vote_tvalid, 1);
      check("r3_vote_data_hold", {m_vote_lanes, m_vote_tlast, m_vote_tdata},
            pk(3'b111, 1'b1, 32'hC, 32'hB, 32'hA));
      check("r3_s_axis_tready_low", s_axis_tready, 0);
    end
    vc0 = vote_cnt;
    @(posedge clk); #1;
    m_vote_tready = 1'b1;
    repeat (4) @(negedge clk);
    check("r3_single_transfer", vote_cnt - vc0, 1);
    check("r3_vote_tvalid_off", m_vote_tvalid, 0);
    @(posedge clk); #1;

    // Round 4: reset pulsed during COLLECT abandons the round
    s_res_tvalid = 3'b000;
    vc0 = vote_cnt;
    send_sample(32'h44, 1'b0);
    wait_state(2'd2, 20);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("r4_rst_busy", busy, 0);
    check("r4_rst_vote_tvalid", m_vote_tvalid, 0);
    check("r4_rst_req_tvalid", m_req_tvalid, 0);
    check("r4_rst_res_tready", s_res_tready, 0);
    check("r4_rst_lanes", m_vote_lanes, 0);
    check("r4_rst_vote_tdata", m_vote_tdata, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("r4_s_axis_tready", s_axis_tready, 1);
    check("r4_no_vote", vote_cnt - vc0, 0);
    @(posedge clk); #1;
    s_res_tvalid = 3'b111;
    s_res_tdata  = {32'd9, 32'd8, 32'd7};
    exp_q.push_back(pk(3'b111, 1'b1, 32'd9, 32'd8, 32'd7));
    send_sample(32'h55, 1'b1);
    wait_vote_valid(20, lat);
    check("r4_next_latency", lat, 3);
    @(posedge clk); #1;

`ifdef AXIS_VOTE_SCHED_TIMEOUT_EN
    // Round 5: lane 2 silent, timeout after 8 COLLECT cycles
    s_res_tvalid = 3'b011;
    s_res_tdata  = {32'hEE, 32'h2, 32'h1};
    exp_q.push_back(pk(3'b011, 1'b0, 32'h0, 32'h2, 32'h1));
    send_sample(32'h77, 1'b0);
    wait_vote_valid(40, lat);
    check("r5_timeout_latency", lat, 10);
    @(posedge clk); #1;
    s_res_tvalid = 3'b000;
    @(negedge clk);
    check("r5_timeout_count", timeout_count, 1);
    check("r5_stale_ready", s_res_tready, 3'b100);
    @(posedge clk); #1;

    // Round 6: lane 2's late result is flushed, the next one captured
    send_sample(32'h78, 1'b1);
    wait_state(2'd2, 20);
    check("r6_collect_ready", s_res_tready, 3'b111);
    s_res_tvalid = 3'b100;
    s_res_tdata  = {32'hBAD, 32'h0, 32'h0};
    @(posedge clk); #1;
    s_res_tvalid = 3'b111;
    s_res_tdata  = {32'h3C, 32'h31, 32'h30};
    exp_q.push_back(pk(3'b111, 1'b1, 32'h3C, 32'h31, 32'h30));
    @(negedge clk);
    check("r6_stale_cleared", s_res_tready, 3'b111);
    wait_vote_valid(20, lat);
    check("r6_timeout_count", timeout_count, 1);
    @(posedge clk); #1;
`else
    // Round 5: lane 0 silent for 5000 cycles, no timeout without the feature
    s_res_tvalid = 3'b110;
    s_res_tdata  = {32'h62, 32'h61, 32'h0};
    send_sample(32'h66, 1'b0);
    repeat (5000) @(negedge clk);
    check("r5_no_timeout_valid", m_vote_tvalid, 0);
    check("r5_still_collect", state_dbg, 2'd2);
    check("r5_res_tready", s_res_tready, 3'b001);
    check("r5_busy", busy, 1);
    s_res_tvalid = 3'b111;
    s_res_tdata  = {32'h62, 32'h61, 32'h99};
    exp_q.push_back(pk(3'b111, 1'b0, 32'h62, 32'h61, 32'h99));
    wait_vote_valid(20, lat);
    check("r5_timeout_count", timeout_count, 0);
    @(posedge clk); #1;
`endif

    repeat (3) @(posedge clk);
    check("exp_q_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/axis_vote_scheduler.md
AXIS_VOTE_SCHEDULER -- requirements
Module: axis_vote_scheduler

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the width of the sample and per-lane result words.
REQ-002 Parameter TIMEOUT_CYCLES, default 1024, SHALL set the COLLECT timeout in clk cycles; legal range 2..65535.
REQ-003 clk  input  1  single clock; all logic SHALL be rising-edge.
REQ-004 rst  input  1  reset, asynchronous assert, active-high.
REQ-005 s_axis_tdata/tvalid/tready/tlast  in/in/out/in  DATA_WIDTH/1/1/1  input sample stream.
REQ-006 m_req_tdata/tlast  output  DATA_WIDTH/1  sample broadcast to three classifier lanes.
REQ-007 m_req_tvalid  output  3  per-lane request valid; m_req_tready  input  3  per-lane request ready.
REQ-008 s_res_tdata  input  3*DATA_WIDTH  lane i result at bits [i*DATA_WIDTH +: DATA_WIDTH]; s_res_tvalid  input  3; s_res_tready  output  3.
REQ-009 m_vote_tdata  output  3*DATA_WIDTH  collected results in the same packing; m_vote_tvalid  output  1; m_vote_tready  input  1; m_vote_tlast  output  1.
REQ-010 m_vote_lanes  output  3  mask of lanes whose result in m_vote_tdata is valid.
REQ-011 busy  output  1  high in any state other than IDLE.
REQ-012 timeout_count  output  16  saturating count of timed-out rounds.

Function
REQ-013 The FSM SHALL have the states IDLE, DISPATCH, COLLECT and EMIT, and SHALL process exactly one sample per round.
REQ-014 IDLE: s_axis_tready=1; on an input handshake, latch tdata/tlast, set pend=3'b111, and enter DISPATCH next cycle.
REQ-015 DISPATCH: m_req_tvalid=pend and m_req_tdata/tlast held stable; lane i handshake clears pend[i]; when pend becomes 0 (including simultaneous handshakes), clear got and timer and enter COLLECT.
REQ-016 COLLECT: s_res_tready[i]=~got[i] | stale[i]; a handshake on a non-stale lane captures the result and sets got[i]; a handshake on a stale lane discards data and clears stale[i].
REQ-017 COLLECT: when got==3'b111 after this cycle's captures, enter EMIT with m_vote_lanes=3'b111.
REQ-018 Timer SHALL increment once per COLLECT cycle; if it equals TIMEOUT_CYCLES-1 and got (including same-cycle captures) != 3'b111, enter EMIT with lanes=got, set stale[i] for each lane with ~got[i], and increment timeout_count, saturating at 16'hFFFF.
REQ-019 A result arriving in the expiry cycle SHALL be captured and counted as got.
REQ-020 EMIT: m_vote_tvalid=1 with tdata/tlast/lanes stable until m_vote_tready; on handshake enter IDLE.
REQ-021 m_vote_tlast SHALL equal the latched input tlast; uncaptured lanes' data SHALL be zero.
REQ-022 Outside COLLECT, s_res_tready[i]=stale[i]; a stale-lane handshake SHALL clear stale[i] and discard data.
REQ-023 s_axis_tready=0 and m_req_tvalid=0 outside IDLE and DISPATCH respectively, so that no sample is dropped or duplicated.
REQ-024 Minimum round latency, from the input handshake to m_vote_tvalid with all ready/valid held high, SHALL be 3 cycles.

Reset
REQ-025 On rst: FSM=IDLE, pend=got=stale=0, timer=0, timeout_count=0, all data registers 0, m_req_tvalid=0, m_vote_tvalid=0, m_vote_lanes=0, s_res_tready=0, busy=0; s_axis_tready SHALL be 1 after deassertion.
REQ-026 Reset asserted mid-round SHALL abandon the round with no output produced.

Configuration
REQ-027 With AXIS_VOTE_SCHED_TIMEOUT_EN defined, the timer, stale tracking and timeout_count SHALL be implemented per REQ-018/022.
REQ-028 Without AXIS_VOTE_SCHED_TIMEOUT_EN: COLLECT SHALL wait indefinitely for all lanes, m_vote_lanes is always 3'b111, stale is always 0, and timeout_count is tied to 0.

Verification
REQ-029 All readies/valids high, sample 0x11, results 5/5/7 in the first COLLECT cycle -> m_vote_tdata={7,5,5}, lanes=111, valid 3 cycles after the input handshake.
REQ-030 Lane 1 m_req_tready delayed 4 cycles -> m_req_tvalid=3'b010 held with data stable for 4 cycles, then COLLECT.
REQ-031 TIMEOUT_CYCLES=8, lane 2 silent -> EMIT after 8 COLLECT cycles with lanes=011, timeout_count=1; lane 2's late result in the next round is discarded and its following result captured.
REQ-032 m_vote_tready low for 5 cycles -> outputs stable, s_axis_tready=0 throughout, one transfer only.
REQ-033 rst pulsed during COLLECT -> all outputs at reset values, no m_vote_tvalid; next sample processed normally.
REQ-034 Macro undefined, lane 0 delayed 5000 cycles -> no timeout; EMIT with lanes=111, timeout_count=0.
